// File: rtl/misc_sched_pkg.sv
// Shared types and constants for the Misc datapath scheduler.
// Holds the FSM state encoding, the operand/result widths, and the
// helper that sizes requester IDs.
package misc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        RESULT = 2'd2
    } sched_state_t;

    localparam int OPA_W = 8;
    localparam int OPB_W = 4;
    localparam int OPC_W = 8;
    localparam int RES_W = 8;

    // Number of bits needed to name one of n requesters.
    // The result is never 0, so a one-requester build still gets a legal vector.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// The search starts at PTR and wraps modulo NREQ. The request vector is
// doubled, so looking at the NREQ bits that start at PTR is the same as
// rotating the requests down by PTR. The lowest set bit of that window is
// the offset of the winner from PTR.
module rr_picker
    import misc_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = idw(NREQ)
) (
    input  logic [NREQ-1:0] REQ,
    input  logic [IDW-1:0]  PTR,
    output logic            GNT_VALID,
    output logic [IDW-1:0]  GNT_IDX
);

    localparam logic [IDW:0] NREQ_V = (IDW+1)'(NREQ);

    logic [2*NREQ-1:0] doubled;
    logic [NREQ-1:0]   rotated;
    logic [IDW-1:0]    offset;
    logic [IDW:0]      sum;

    // Rotate the requests so PTR sits at bit 0. Priority-encode the lowest set
    // bit, then add PTR back and wrap modulo NREQ to get the absolute index.
    always_comb begin
        doubled   = {REQ, REQ};
        rotated   = '0;
        offset    = '0;
        GNT_VALID = |REQ;
        for (int j = 0; j < NREQ; j++) begin
            rotated[j] = doubled[int'(PTR) + j];
        end
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                offset = IDW'(j);
            end
        end
        sum = {1'b0, PTR} + {1'b0, offset};
        if (sum >= NREQ_V) begin
            sum = sum - NREQ_V;
        end
        GNT_IDX = sum[IDW-1:0];
    end

endmodule

// File: rtl/misc_dp_scheduler.sv
// Lets NREQ requesters take turns on one combinational Misc datapath.
// A round-robin winner's operands are registered onto the datapath and held
// for SETTLE cycles. XOUT1/XOUT2 are then captured and returned, tagged with
// the winner's ID, over a valid/ready result channel.
module misc_dp_scheduler
    import misc_sched_pkg::*;
#(
    parameter  int NREQ   = 4,
    parameter  int SETTLE = 1,
    localparam int IDW    = idw(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ_VALID,
    output logic [NREQ-1:0]       REQ_READY,
    input  logic [NREQ*OPA_W-1:0] REQ_A,
    input  logic [NREQ*OPB_W-1:0] REQ_B,
    input  logic [NREQ*OPC_W-1:0] REQ_C,
    output logic [OPA_W-1:0]      DP_A,
    output logic [OPB_W-1:0]      DP_B,
    output logic [OPC_W-1:0]      DP_C,
    input  logic [RES_W-1:0]      DP_XOUT1,
    input  logic [RES_W-1:0]      DP_XOUT2,
    output logic                  RES_VALID,
    input  logic                  RES_READY,
    output logic [IDW-1:0]        RES_ID,
    output logic [RES_W-1:0]      RES_X1,
    output logic [RES_W-1:0]      RES_X2,
    output logic                  BUSY
);

    localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    sched_state_t     state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [OPA_W-1:0] dpA_q, dpA_d;
    logic [OPB_W-1:0] dpB_q, dpB_d;
    logic [OPC_W-1:0] dpC_q, dpC_d;
    logic             resValid_q, resValid_d;
    logic [IDW-1:0]   resId_q, resId_d;
    logic [RES_W-1:0] resX1_q, resX1_d;
    logic [RES_W-1:0] resX2_q, resX2_d;

    logic             gntValid;
    logic [IDW-1:0]   gntIdx;
    logic             accept;

    rr_picker #(
        .NREQ(NREQ)
    ) picker (
        .REQ      (REQ_VALID),
        .PTR      (ptr_q),
        .GNT_VALID(gntValid),
        .GNT_IDX  (gntIdx)
    );

    // Accept a request only from IDLE. The ready strobe is combinational from
    // the valids and the state. It is forced low while reset is asserted, so
    // nothing is handshaken during reset.
    always_comb begin
        REQ_READY = '0;
        accept    = (state_q == IDLE) && gntValid && !RST;
        if (accept) begin
            REQ_READY[gntIdx] = 1'b1;
        end
    end

    // Next-state logic for the three-phase transaction:
    // latch the operands, let the datapath settle, then hold the result until
    // the consumer takes it.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        dpA_d      = dpA_q;
        dpB_d      = dpB_q;
        dpC_d      = dpC_q;
        resValid_d = resValid_q;
        resId_d    = resId_q;
        resX1_d    = resX1_q;
        resX2_d    = resX2_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dpA_d   = REQ_A[int'(gntIdx)*OPA_W +: OPA_W];
                    dpB_d   = REQ_B[int'(gntIdx)*OPB_W +: OPB_W];
                    dpC_d   = REQ_C[int'(gntIdx)*OPC_W +: OPC_W];
                    resId_d = gntIdx;
                    ptr_d   = (gntIdx == IDW'(NREQ - 1)) ? '0 : gntIdx + IDW'(1);
                    cnt_d   = CNTW'(SETTLE - 1);
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNTW'(1);
                end else begin
                    resX1_d    = DP_XOUT1;
                    resX2_d    = DP_XOUT2;
                    resValid_d = 1'b1;
                    state_d    = RESULT;
                end
            end
            RESULT: begin
                if (RES_READY) begin
                    resValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset drops any in-flight work immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            dpA_q      <= '0;
            dpB_q      <= '0;
            dpC_q      <= '0;
            resValid_q <= 1'b0;
            resId_q    <= '0;
            resX1_q    <= '0;
            resX2_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            dpA_q      <= dpA_d;
            dpB_q      <= dpB_d;
            dpC_q      <= dpC_d;
            resValid_q <= resValid_d;
            resId_q    <= resId_d;
            resX1_q    <= resX1_d;
            resX2_q    <= resX2_d;
        end
    end

    assign DP_A      = dpA_q;
    assign DP_B      = dpB_q;
    assign DP_C      = dpC_q;
    assign RES_VALID = resValid_q;
    assign RES_ID    = resId_q;
    assign RES_X1    = resX1_q;
    assign RES_X2    = resX2_q;
    assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_misc_dp_scheduler.sv
// Directed testbench for misc_dp_scheduler.
// One instance uses SETTLE=1 and is driven by a Misc stand-in with
// XOUT1 = A ^ C and XOUT2 = A + 4*B.
// A second instance uses SETTLE=3. Its XOUT1 is stepped by hand, and it is
// also the one that takes the asynchronous reset in the middle of DRIVE.
module tb_misc_dp_scheduler;

    localparam int NREQ = 4;

    int testsRun    = 0;
    int testsFailed = 0;

    logic clock;

    // Signals for the SETTLE=1 instance.
    logic        reset;
    logic [3:0]  reqValid;
    logic [3:0]  reqReady;
    logic [31:0] reqA;
    logic [15:0] reqB;
    logic [31:0] reqC;
    logic [7:0]  dpA;
    logic [3:0]  dpB;
    logic [7:0]  dpC;
    logic [7:0]  xout1;
    logic [7:0]  xout2;
    logic        resValid;
    logic        resReady;
    logic [1:0]  resId;
    logic [7:0]  resX1;
    logic [7:0]  resX2;
    logic        busy;

    // Signals for the SETTLE=3 instance.
    logic        reset3;
    logic [3:0]  reqValid3;
    logic [3:0]  reqReady3;
    logic [31:0] reqA3;
    logic [15:0] reqB3;
    logic [31:0] reqC3;
    logic [7:0]  dpA3;
    logic [3:0]  dpB3;
    logic [7:0]  dpC3;
    logic [7:0]  xout1_3;
    logic [7:0]  xout2_3;
    logic        resValid3;
    logic        resReady3;
    logic [1:0]  resId3;
    logic [7:0]  resX1_3;
    logic [7:0]  resX2_3;
    logic        busy3;

    misc_dp_scheduler #(.NREQ(NREQ), .SETTLE(1)) dut1 (
        .CLK(clock), .RST(reset),
        .REQ_VALID(reqValid), .REQ_READY(reqReady),
        .REQ_A(reqA), .REQ_B(reqB), .REQ_C(reqC),
        .DP_A(dpA), .DP_B(dpB), .DP_C(dpC),
        .DP_XOUT1(xout1), .DP_XOUT2(xout2),
        .RES_VALID(resValid), .RES_READY(resReady),
        .RES_ID(resId), .RES_X1(resX1), .RES_X2(resX2),
        .BUSY(busy)
    );

    misc_dp_scheduler #(.NREQ(NREQ), .SETTLE(3)) dut3 (
        .CLK(clock), .RST(reset3),
        .REQ_VALID(reqValid3), .REQ_READY(reqReady3),
        .REQ_A(reqA3), .REQ_B(reqB3), .REQ_C(reqC3),
        .DP_A(dpA3), .DP_B(dpB3), .DP_C(dpC3),
        .DP_XOUT1(xout1_3), .DP_XOUT2(xout2_3),
        .RES_VALID(resValid3), .RES_READY(resReady3),
        .RES_ID(resId3), .RES_X1(resX1_3), .RES_X2(resX2_3),
        .BUSY(busy3)
    );

    // Stand-in for the combinational Misc datapath behind the first instance.
    always_comb begin
        xout1 = dpA ^ dpC;
        xout2 = dpA + {2'b00, dpB, 2'b00};
    end

    // Free-running 10 ns clock shared by both instances.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] a, input logic [3:0] b, input logic [7:0] c);
        reqA[idx*8 +: 8] = a;
        reqB[idx*4 +: 4] = b;
        reqC[idx*8 +: 8] = c;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Directed test sequence.
    initial begin
        logic [31:0] expReady;
        bit          expAcc;
        int          grant;

        reset     = 1'b1;
        reset3    = 1'b1;
        reqValid  = '0;
        reqA      = '0;
        reqB      = '0;
        reqC      = '0;
        resReady  = 1'b0;
        reqValid3 = '0;
        reqA3     = 32'h3301_0044;
        reqB3     = '0;
        reqC3     = '0;
        xout1_3   = 8'd0;
        xout2_3   = 8'h77;
        resReady3 = 1'b0;

        // Reset state.
        tick();
        tick();
        checkOutput("rst_res_valid", {31'd0, resValid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_dp_a", {24'd0, dpA}, 32'd0);
        checkOutput("rst_res_id", {30'd0, resId}, 32'd0);
        checkOutput("rst_req_ready", {28'd0, reqReady}, 32'd0);
        reset  = 1'b0;
        reset3 = 1'b0;
        tick();

        // Single request from requester 2, SETTLE=1.
        applyStimulus(2, 8'd20, 4'd3, 8'h0A);
        reqValid = 4'b0100;
        resReady = 1'b1;
        #1;
        checkOutput("t1_req_ready", {28'd0, reqReady}, 32'h4);
        checkOutput("t1_busy_idle", {31'd0, busy}, 32'd0);
        tick();
        reqValid = 4'b0000;
        #1;
        checkOutput("t1_ready_drop", {28'd0, reqReady}, 32'd0);
        checkOutput("t1_busy_drive", {31'd0, busy}, 32'd1);
        checkOutput("t1_dp_a", {24'd0, dpA}, 32'd20);
        checkOutput("t1_dp_b", {28'd0, dpB}, 32'd3);
        checkOutput("t1_dp_c", {24'd0, dpC}, 32'h0A);
        checkOutput("t1_valid_early", {31'd0, resValid}, 32'd0);
        tick();
        checkOutput("t1_res_valid", {31'd0, resValid}, 32'd1);
        checkOutput("t1_res_id", {30'd0, resId}, 32'd2);
        checkOutput("t1_res_x1", {24'd0, resX1}, 32'd30);
        checkOutput("t1_res_x2", {24'd0, resX2}, 32'd32);
        tick();
        checkOutput("t1_valid_done", {31'd0, resValid}, 32'd0);
        checkOutput("t1_busy_done", {31'd0, busy}, 32'd0);

        // Serve requester 3, which leaves the pointer at 0.
        applyStimulus(3, 8'd5, 4'd1, 8'h01);
        reqValid = 4'b1000;
        #1;
        checkOutput("wrap_ready3", {28'd0, reqReady}, 32'h8);
        tick();
        reqValid = 4'b0000;
        tick();
        checkOutput("wrap_id3", {30'd0, resId}, 32'd3);
        tick();

        // Only requester 1 is valid, so the search goes 0 -> 1.
        // The result is then held back for 5 cycles.
        applyStimulus(1, 8'd100, 4'd15, 8'hFF);
        applyStimulus(3, 8'd7, 4'd2, 8'h30);
        reqValid = 4'b0010;
        resReady = 1'b0;
        #1;
        checkOutput("wrap_ready1", {28'd0, reqReady}, 32'h2);
        tick();
        reqValid = 4'b0000;
        tick();
        checkOutput("bp_id_first", {30'd0, resId}, 32'd1);
        reqValid = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_valid", {31'd0, resValid}, 32'd1);
            checkOutput("bp_id", {30'd0, resId}, 32'd1);
            checkOutput("bp_x1", {24'd0, resX1}, 32'd155);
            checkOutput("bp_x2", {24'd0, resX2}, 32'd160);
            checkOutput("bp_ready", {28'd0, reqReady}, 32'd0);
        end
        resReady = 1'b1;
        tick();
        resReady = 1'b0;
        #1;
        checkOutput("bp_valid_done", {31'd0, resValid}, 32'd0);
        checkOutput("bp_busy_done", {31'd0, busy}, 32'd0);
        // The pointer should now be 2, so with 1 and 3 valid, requester 3 wins.
        checkOutput("ptr2_ready3", {28'd0, reqReady}, 32'h8);
        tick();
        reqValid = 4'b0000;
        resReady = 1'b1;
        tick();
        checkOutput("ptr2_id", {30'd0, resId}, 32'd3);
        checkOutput("ptr2_x1", {24'd0, resX1}, 32'd55);
        checkOutput("ptr2_x2", {24'd0, resX2}, 32'd15);
        tick();

        // All requesters valid: grants go 0,1,2,3,0, one accept every 3 cycles.
        for (int i = 0; i < NREQ; i++) begin
            applyStimulus(i, 8'(16 * i + 1), 4'(i), 8'(i));
        end
        reqValid = 4'hF;
        #1;
        for (int k = 0; k < 15; k++) begin
            expAcc   = (k % 3 == 0);
            grant    = (k / 3) % NREQ;
            expReady = expAcc ? (32'd1 << grant) : 32'd0;
            checkOutput("rr_ready", {28'd0, reqReady}, expReady);
            checkOutput("rr_busy", {31'd0, busy}, expAcc ? 32'd0 : 32'd1);
            if (k % 3 == 2) begin
                checkOutput("rr_res_id", {30'd0, resId}, 32'(grant));
            end
            tick();
        end
        reqValid = 4'b0000;
        tick();

        // SETTLE=3: capture must see the last DRIVE-cycle XOUT1 value.
        reqValid3 = 4'b0100;
        resReady3 = 1'b1;
        xout1_3   = 8'd10;
        #1;
        checkOutput("s3_ready", {28'd0, reqReady3}, 32'h4);
        tick();
        reqValid3 = 4'b0000;
        checkOutput("s3_busy", {31'd0, busy3}, 32'd1);
        checkOutput("s3_dp_a", {24'd0, dpA3}, 32'd1);
        tick();
        xout1_3 = 8'd11;
        checkOutput("s3_valid_c2", {31'd0, resValid3}, 32'd0);
        tick();
        xout1_3 = 8'd12;
        checkOutput("s3_valid_c3", {31'd0, resValid3}, 32'd0);
        tick();
        checkOutput("s3_valid", {31'd0, resValid3}, 32'd1);
        checkOutput("s3_x1", {24'd0, resX1_3}, 32'd12);
        checkOutput("s3_x2", {24'd0, resX2_3}, 32'h77);
        checkOutput("s3_id", {30'd0, resId3}, 32'd2);
        tick();

        // Asynchronous reset in the middle of DRIVE.
        reqValid3 = 4'b1001;
        #1;
        checkOutput("ar_ready_pre", {28'd0, reqReady3}, 32'h8);
        tick();
        reqValid3 = 4'b0001;
        checkOutput("ar_dp_a_pre", {24'd0, dpA3}, 32'h33);
        tick();
        #2;
        reset3 = 1'b1;
        #1;
        checkOutput("ar_dp_a", {24'd0, dpA3}, 32'd0);
        checkOutput("ar_dp_b", {28'd0, dpB3}, 32'd0);
        checkOutput("ar_dp_c", {24'd0, dpC3}, 32'd0);
        checkOutput("ar_busy", {31'd0, busy3}, 32'd0);
        checkOutput("ar_valid", {31'd0, resValid3}, 32'd0);
        checkOutput("ar_id", {30'd0, resId3}, 32'd0);
        checkOutput("ar_x1", {24'd0, resX1_3}, 32'd0);
        checkOutput("ar_x2", {24'd0, resX2_3}, 32'd0);
        checkOutput("ar_ready_in_rst", {28'd0, reqReady3}, 32'd0);
        #1;
        reset3 = 1'b0;
        #1;
        checkOutput("ar_ready_post", {28'd0, reqReady3}, 32'h1);
        tick();
        reqValid3 = 4'b0000;
        checkOutput("ar_dp_a_post", {24'd0, dpA3}, 32'h44);
        checkOutput("ar_busy_post", {31'd0, busy3}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
